// File: rtl/led_place_8x8_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// led_place_pkg
// Shared types and constants for the 8x8 LED frame sequencer.
//   state_t  : playback FSM states
//   FRAME_W  : width of one 8x8 frame (bit r*8+c = row r, column c)
//   idx_w()  : width of a slot index for a given slot count
// -----------------------------------------------------------------------------
package led_place_pkg;

    localparam int FRAME_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SHOW = 2'd2,
        DONE = 2'd3
    } state_t;

    // A single-slot buffer still needs a 1-bit index signal.
    function automatic int idx_w(input int slots);
        return (slots > 1) ? $clog2(slots) : 1;
    endfunction

endpackage

// File: rtl/led_place_8x8_sequencer_if.sv
// -----------------------------------------------------------------------------
// led_place_8x8_sequencer_if
// Frame write port (valid/ready) into the sequencer's slot buffer.
//   i_wr_valid : write request            (master -> slave)
//   o_wr_ready : write accepted when valid&&ready (slave -> master)
//   i_wr_addr  : target slot              (master -> slave)
//   i_wr_data  : 64-bit frame             (master -> slave)
// -----------------------------------------------------------------------------
interface led_place_8x8_sequencer_if
    import led_place_pkg::*;
#(
    parameter int SLOTS = 4
) ();

    localparam int IW = idx_w(SLOTS);

    logic               i_wr_valid;
    logic               o_wr_ready;
    logic [IW-1:0]      i_wr_addr;
    logic [FRAME_W-1:0] i_wr_data;

    modport master (
        output i_wr_valid,
        output i_wr_addr,
        output i_wr_data,
        input  o_wr_ready
    );

    modport slave (
        input  i_wr_valid,
        input  i_wr_addr,
        input  i_wr_data,
        output o_wr_ready
    );

endinterface

// File: rtl/led_place_8x8_sequencer_tick_gen.sv
// -----------------------------------------------------------------------------
// led_tick_gen
// Prescaler counting 0..PRESCALE-1; o_tick is high while the count sits at
// PRESCALE-1 and the counter is not being cleared.
//   aclk    : system clock
//   aresetn : synchronous active-low reset
//   i_clr   : synchronous clear, holds the count at 0
//   o_tick  : one dwell tick
// -----------------------------------------------------------------------------
module led_tick_gen #(
    parameter int PRESCALE = 256
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge aclk) begin
        if (!aresetn || i_clr) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign o_tick = !i_clr && (count == LAST);

endmodule

// File: rtl/led_place_8x8_sequencer.sv
// -----------------------------------------------------------------------------
// led_place_8x8_sequencer
// Buffers SLOTS frames written over a valid/ready port and plays slots
// 0..last in order, each for dwell*PRESCALE ticks plus one LOAD cycle,
// one-shot or looped.
//   aclk, aresetn : clock, synchronous active-low reset
//   wr            : frame write port (slave side)
//   i_run         : level, 1 = play, 0 = stop
//   i_loop        : wrap from last slot to slot 0 (sampled at final frame)
//   i_last_idx    : last slot played (latched at start)
//   i_dwell       : ticks per frame, 0 treated as 1 (latched at start)
//   o_led_data    : frame to the scanner
//   o_frame_idx   : slot currently shown
//   o_busy        : high in LOAD or SHOW
//   o_done        : one-cycle pulse at the end of a one-shot run
// -----------------------------------------------------------------------------
module led_place_8x8_sequencer
    import led_place_pkg::*;
#(
    parameter int SLOTS    = 4,
    parameter int PRESCALE = 256,
    parameter int DWELL_W  = 16
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    led_place_8x8_sequencer_if.slave   wr,
    input  logic                       i_run,
    input  logic                       i_loop,
    input  logic [idx_w(SLOTS)-1:0]    i_last_idx,
    input  logic [DWELL_W-1:0]         i_dwell,
    output logic [FRAME_W-1:0]         o_led_data,
    output logic [idx_w(SLOTS)-1:0]    o_frame_idx,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int IW = idx_w(SLOTS);

    state_t             state;
    logic [IW-1:0]      idx;
    logic [IW-1:0]      last_idx;
    logic [DWELL_W-1:0] dwell_lat;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [FRAME_W-1:0] slots [SLOTS];
    logic               tick;

    // Only the slot being copied to the output this cycle is blocked.
    assign wr.o_wr_ready = !((state == LOAD) && (wr.i_wr_addr == idx));

    // NOTE: the slot buffer must read as blank after reset, so it is cleared
    // explicitly; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < SLOTS; i++) begin
                slots[i] <= '0;
            end
        end else if (wr.i_wr_valid && wr.o_wr_ready) begin
            slots[wr.i_wr_addr] <= wr.i_wr_data;
        end
    end

    led_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .aclk    (aclk),
        .aresetn (aresetn),
        .i_clr   (state != SHOW),
        .o_tick  (tick)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state       <= IDLE;
            idx         <= '0;
            last_idx    <= '0;
            dwell_lat   <= '0;
            dwell_cnt   <= '0;
            o_led_data  <= '0;
            o_frame_idx <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_run) begin
                        last_idx  <= i_last_idx;
                        dwell_lat <= (i_dwell == '0) ? DWELL_W'(1) : i_dwell;
                        idx       <= '0;
                        state     <= LOAD;
                        o_busy    <= 1'b1;
                    end
                end
                LOAD: begin
                    if (!i_run) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else begin
                        o_led_data  <= slots[idx];
                        o_frame_idx <= idx;
                        dwell_cnt   <= dwell_lat;
                        state       <= SHOW;
                    end
                end
                SHOW: begin
                    if (!i_run) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else if (tick) begin
                        dwell_cnt <= dwell_cnt - DWELL_W'(1);
                        if (dwell_cnt == DWELL_W'(1)) begin
                            if (idx < last_idx) begin
                                idx   <= idx + IW'(1);
                                state <= LOAD;
                            end else if (i_loop) begin
                                idx   <= '0;
                                state <= LOAD;
                            end else begin
                                state  <= DONE;
                                o_busy <= 1'b0;
                                o_done <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_place_8x8_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_place_8x8_sequencer
// Directed bench for led_place_8x8_sequencer with SLOTS=4, PRESCALE=4.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_led_place_8x8_sequencer;

    localparam int SLOTS    = 4;
    localparam int PRESCALE = 4;
    localparam int DWELL_W  = 16;

    logic        aclk;
    logic        aresetn;
    logic        i_run;
    logic        i_loop;
    logic [1:0]  i_last_idx;
    logic [15:0] i_dwell;
    logic [63:0] o_led_data;
    logic [1:0]  o_frame_idx;
    logic        o_busy;
    logic        o_done;

    int passed = 0;
    int total  = 0;
    logic done_seen;
    int   n;

    led_place_8x8_sequencer_if #(.SLOTS(SLOTS)) wr_bus ();

    led_place_8x8_sequencer #(
        .SLOTS    (SLOTS),
        .PRESCALE (PRESCALE),
        .DWELL_W  (DWELL_W)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .wr          (wr_bus),
        .i_run       (i_run),
        .i_loop      (i_loop),
        .i_last_idx  (i_last_idx),
        .i_dwell     (i_dwell),
        .o_led_data  (o_led_data),
        .o_frame_idx (o_frame_idx),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Counts falling edges until o_led_data changes (bounded at 100).
    task automatic wait_change(output int cycles);
        logic [63:0] prev;
        prev   = o_led_data;
        cycles = 0;
        do begin
            @(negedge aclk);
            cycles++;
            done_seen = done_seen | o_done;
        end while (o_led_data === prev && cycles < 100);
    endtask

    task automatic write_slot(input logic [1:0] addr, input logic [63:0] data);
        wr_bus.i_wr_valid = 1'b1;
        wr_bus.i_wr_addr  = addr;
        wr_bus.i_wr_data  = data;
        @(negedge aclk);
        wr_bus.i_wr_valid = 1'b0;
    endtask

    initial begin
        aresetn           = 1'b0;
        i_run             = 1'b0;
        i_loop            = 1'b0;
        i_last_idx        = '0;
        i_dwell           = '0;
        wr_bus.i_wr_valid = 1'b0;
        wr_bus.i_wr_addr  = '0;
        wr_bus.i_wr_data  = '0;
        done_seen         = 1'b0;

        // Reset then idle
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check("rst_led", o_led_data, 64'h0);
        check("rst_busy", {63'b0, o_busy}, 64'h0);
        check("rst_ready", {63'b0, wr_bus.o_wr_ready}, 64'h1);
        check("rst_done", {63'b0, o_done}, 64'h0);
        check("rst_idx", {62'b0, o_frame_idx}, 64'h0);

        // One-shot play, dwell 2 -> 9 cycles per frame
        write_slot(2'd0, 64'h01);
        write_slot(2'd1, 64'h02);
        write_slot(2'd2, 64'h04);
        write_slot(2'd3, 64'h08);
        i_last_idx = 2'd3;
        i_dwell    = 16'd2;
        i_loop     = 1'b0;
        i_run      = 1'b1;
        @(negedge aclk);
        check("os_load_busy", {63'b0, o_busy}, 64'h1);
        check("os_load_led", o_led_data, 64'h0);
        @(negedge aclk);
        check("os_f0", o_led_data, 64'h01);
        check("os_f0_idx", {62'b0, o_frame_idx}, 64'h0);
        wait_change(n);
        check("os_hold0", 64'(n), 64'd9);
        check("os_f1", o_led_data, 64'h02);
        wait_change(n);
        check("os_hold1", 64'(n), 64'd9);
        check("os_f2", o_led_data, 64'h04);
        wait_change(n);
        check("os_hold2", 64'(n), 64'd9);
        check("os_f3", o_led_data, 64'h08);
        check("os_f3_idx", {62'b0, o_frame_idx}, 64'h3);
        n = 0;
        while (o_done !== 1'b1 && n < 100) begin
            @(negedge aclk);
            n++;
        end
        i_run = 1'b0;
        check("os_done_lat", 64'(n), 64'd8);
        check("os_done_led", o_led_data, 64'h08);
        check("os_done_busy", {63'b0, o_busy}, 64'h0);
        @(negedge aclk);
        check("os_done_pulse", {63'b0, o_done}, 64'h0);
        check("os_idle_led", o_led_data, 64'h08);

        // Loop over slots 0..1 with zero dwell -> 5 cycles per frame
        i_last_idx = 2'd1;
        i_loop     = 1'b1;
        i_dwell    = 16'd0;
        done_seen  = 1'b0;
        i_run      = 1'b1;
        repeat (2) @(negedge aclk);
        check("lp_f0", o_led_data, 64'h01);
        check("lp_f0_idx", {62'b0, o_frame_idx}, 64'h0);
        wait_change(n);
        check("lp_hold_a", 64'(n), 64'd5);
        check("lp_idx_a", {62'b0, o_frame_idx}, 64'h1);
        wait_change(n);
        check("lp_hold_b", 64'(n), 64'd5);
        check("lp_idx_b", {62'b0, o_frame_idx}, 64'h0);
        wait_change(n);
        check("lp_hold_c", 64'(n), 64'd5);
        check("lp_idx_c", {62'b0, o_frame_idx}, 64'h1);

        // Write collision: slot 0 during its LOAD cycle
        repeat (4) @(negedge aclk);
        wr_bus.i_wr_valid = 1'b1;
        wr_bus.i_wr_addr  = 2'd0;
        wr_bus.i_wr_data  = 64'hAA;
        #1;
        check("col_ready_lo", {63'b0, wr_bus.o_wr_ready}, 64'h0);
        @(negedge aclk);
        check("col_old_frame", o_led_data, 64'h01);
        #1;
        check("col_ready_hi", {63'b0, wr_bus.o_wr_ready}, 64'h1);
        @(negedge aclk);
        wr_bus.i_wr_valid = 1'b0;
        wait_change(n);
        check("col_pass_f1", o_led_data, 64'h02);
        wait_change(n);
        check("col_new_f0", o_led_data, 64'hAA);
        check("col_new_idx", {62'b0, o_frame_idx}, 64'h0);
        check("lp_no_done", {63'b0, done_seen}, 64'h0);

        // Stop mid-run during SHOW of slot 2
        i_run = 1'b0;
        @(negedge aclk);
        check("stop_lp_busy", {63'b0, o_busy}, 64'h0);
        i_last_idx = 2'd3;
        i_loop     = 1'b0;
        i_dwell    = 16'd1;
        i_run      = 1'b1;
        repeat (2) @(negedge aclk);
        check("st_f0", o_led_data, 64'hAA);
        wait_change(n);
        check("st_f1", o_led_data, 64'h02);
        wait_change(n);
        check("st_f2", o_led_data, 64'h04);
        i_run = 1'b0;
        @(negedge aclk);
        check("st_busy", {63'b0, o_busy}, 64'h0);
        check("st_led", o_led_data, 64'h04);
        check("st_idx", {62'b0, o_frame_idx}, 64'h2);
        check("st_done", {63'b0, o_done}, 64'h0);
        @(negedge aclk);
        check("st_done2", {63'b0, o_done}, 64'h0);
        check("st_led2", o_led_data, 64'h04);

        // Reset mid-run during SHOW
        i_run = 1'b1;
        repeat (2) @(negedge aclk);
        check("rr_f0", o_led_data, 64'hAA);
        wait_change(n);
        check("rr_f1", o_led_data, 64'h02);
        aresetn = 1'b0;
        @(negedge aclk);
        check("rr_led", o_led_data, 64'h0);
        check("rr_busy", {63'b0, o_busy}, 64'h0);
        check("rr_idx", {62'b0, o_frame_idx}, 64'h0);
        aresetn = 1'b1;
        // Replay shows blank slots, proving the buffer was cleared
        repeat (2) @(negedge aclk);
        check("rr_play_busy", {63'b0, o_busy}, 64'h1);
        check("rr_slot0", o_led_data, 64'h0);
        repeat (5) @(negedge aclk);
        check("rr_idx1", {62'b0, o_frame_idx}, 64'h1);
        check("rr_slot1", o_led_data, 64'h0);
        repeat (5) @(negedge aclk);
        check("rr_idx2", {62'b0, o_frame_idx}, 64'h2);
        check("rr_slot2", o_led_data, 64'h0);
        i_run = 1'b0;
        @(negedge aclk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
